camera_init_ctrl: RTL and testbench

//  Parametrised OV-series sensor bring-up controller: generates XCLK, sequences the

---
 rtl/camera_init_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_camera_init_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_init_ctrl.sv
// camera_init_ctrl: OV-series sensor bring-up controller.
// Generates the free-running XCLK, sequences the sensor reset pin, then walks an
// external register table and issues one 3-phase SCCB write per entry. The table
// may also hold delay entries (addr 8'hF0) and an end marker (16'hFFFF).
module camera_init_ctrl #(
    parameter int         XCLK_DIV   = 4,
    parameter int         SCCB_QTR   = 250,
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int         RST_HOLD   = 1000,
    parameter int         RST_WAIT   = 100000,
    parameter int         GAP_CYC    = 1000,
    parameter int         DELAY_UNIT = 10000,
    parameter int         IDX_W      = 8,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_data,
    output logic             xclk,
    output logic             cam_rst,
    output logic             sioc,
    output logic             siod,
    output logic             siod_oe,
    output logic             busy,
    output logic             done
);

    localparam int HALF    = XCLK_DIV / 2;
    localparam int XC_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MAX_A   = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
    localparam int MAX_B   = (GAP_CYC > DELAY_UNIT) ? GAP_CYC : DELAY_UNIT;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > SCCB_QTR) ? MAX_C : SCCB_QTR;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [XC_W-1:0]  XC_LAST   = XC_W'(HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT - 1);
    localparam logic [CNT_W-1:0] QTR_LAST  = CNT_W'(SCCB_QTR - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(DELAY_UNIT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST_LO, ST_RST_WT, ST_FETCH, ST_START,
        ST_BITS, ST_STOP, ST_GAP, ST_DLY, ST_DONE
    } state_t;

    state_t           state;
    logic [XC_W-1:0]  xclk_cnt;
    logic [CNT_W-1:0] cnt;        // cycles within the current phase / quarter
    logic             fetch_ph;   // 0: address cycle, 1: data-sample cycle
    logic [1:0]       qtr;        // quarter within START/bit/STOP
    logic [4:0]       bit_cnt;    // 0..26 across the three 9-bit phases
    logic [26:0]      frame;      // remaining bits, next bit in [26]
    logic [7:0]       dly_units;  // remaining DELAY_UNIT blocks

    logic at_last;  // current entry is the final table slot
    logic nxt_dc;   // bit after the current one is a don't-care bit
    assign at_last = (tbl_idx == {IDX_W{1'b1}});
    assign nxt_dc  = (bit_cnt == 5'd7) || (bit_cnt == 5'd16) || (bit_cnt == 5'd25);

    // Free-running XCLK divider, independent of the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            xclk_cnt <= '0;
            xclk     <= 1'b0;
        end else if (xclk_cnt == XC_LAST) begin
            xclk_cnt <= '0;
            xclk     <= ~xclk;
        end else begin
            xclk_cnt <= xclk_cnt + 1'b1;
        end
    end

    // Bring-up sequencer with registered bus, reset-pin and status outputs.
    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= AUTO_START ? ST_RST_LO : ST_IDLE;
            cnt       <= '0;
            fetch_ph  <= 1'b0;
            qtr       <= 2'd0;
            bit_cnt   <= 5'd0;
            frame     <= '0;
            dly_units <= 8'd0;
            tbl_idx   <= '0;
            cam_rst   <= 1'b0;
            sioc      <= 1'b1;
            siod      <= 1'b1;
            siod_oe   <= 1'b1;
            busy      <= AUTO_START;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RST_LO;
                        cnt     <= '0;
                        tbl_idx <= '0;
                        cam_rst <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_RST_LO: begin
                    if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        cam_rst <= 1'b1;
                        state   <= ST_RST_WT;
                    end else cnt <= cnt + 1'b1;
                end
                ST_RST_WT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt      <= '0;
                        fetch_ph <= 1'b0;
                        state    <= ST_FETCH;
                    end else cnt <= cnt + 1'b1;
                end
                ST_FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        cnt      <= '0;
                        if (tbl_data == 16'hFFFF) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (tbl_data[15:8] == 8'hF0) begin
                            if (tbl_data[7:0] == 8'd0) begin
                                // Zero-length delay: move straight on.
                                state   <= at_last ? ST_DONE : ST_FETCH;
                                tbl_idx <= at_last ? tbl_idx : tbl_idx + 1'b1;
                                busy    <= ~at_last;
                                done    <= at_last;
                            end else begin
                                dly_units <= tbl_data[7:0];
                                state     <= ST_DLY;
                            end
                        end else begin
                            frame   <= {SLAVE_ADDR, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
                            qtr     <= 2'd0;
                            sioc    <= 1'b1;
                            siod    <= 1'b0;
                            siod_oe <= 1'b1;
                            state   <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (cnt == QTR_LAST) begin
                        cnt <= '0;
                        if (qtr == 2'd0) begin
                            qtr  <= 2'd1;
                            sioc <= 1'b0;
                        end else begin
                            qtr     <= 2'd0;
                            bit_cnt <= 5'd0;
                            siod    <= frame[26];
                            siod_oe <= 1'b1;
                            frame   <= {frame[25:0], 1'b0};
                            state   <= ST_BITS;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                ST_BITS: begin
                    if (cnt == QTR_LAST) begin
                        cnt <= '0;
                        qtr <= qtr + 1'b1;
                        case (qtr)
                            2'd0: sioc <= 1'b1;
                            2'd2: sioc <= 1'b0;
                            2'd3: begin
                                if (bit_cnt == 5'd26) begin
                                    qtr     <= 2'd0;
                                    siod    <= 1'b0;
                                    siod_oe <= 1'b1;
                                    state   <= ST_STOP;
                                end else begin
                                    // siod only moves at the start of Q0.
                                    bit_cnt <= bit_cnt + 1'b1;
                                    siod    <= frame[26];
                                    siod_oe <= ~nxt_dc;
                                    frame   <= {frame[25:0], 1'b0};
                                end
                            end
                            default: ;
                        endcase
                    end else cnt <= cnt + 1'b1;
                end
                ST_STOP: begin
                    if (cnt == QTR_LAST) begin
                        cnt <= '0;
                        qtr <= qtr + 1'b1;
                        if (qtr == 2'd0) sioc <= 1'b1;
                        else if (qtr == 2'd1) siod <= 1'b1;
                        else state <= ST_GAP;
                    end else cnt <= cnt + 1'b1;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt     <= '0;
                        state   <= at_last ? ST_DONE : ST_FETCH;
                        tbl_idx <= at_last ? tbl_idx : tbl_idx + 1'b1;
                        busy    <= ~at_last;
                        done    <= at_last;
                    end else cnt <= cnt + 1'b1;
                end
                ST_DLY: begin
                    if (cnt == UNIT_LAST) begin
                        cnt <= '0;
                        if (dly_units == 8'd1) begin
                            state   <= at_last ? ST_DONE : ST_FETCH;
                            tbl_idx <= at_last ? tbl_idx : tbl_idx + 1'b1;
                            busy    <= ~at_last;
                            done    <= at_last;
                        end else dly_units <= dly_units - 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_init_ctrl.sv
// Testbench for camera_init_ctrl: a timeline model derived from the table
// contents predicts every output cycle by cycle; a bus monitor decodes SCCB bytes.
module tb_camera_init_ctrl;

    localparam int XCLK_DIV   = 4;
    localparam int SCCB_QTR   = 2;
    localparam int RST_HOLD   = 8;
    localparam int RST_WAIT   = 16;
    localparam int GAP_CYC    = 4;
    localparam int DELAY_UNIT = 10;
    localparam int IDX_W      = 4;
    localparam logic [7:0] SLAVE = 8'h42;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [IDX_W-1:0] tbl_idx;
    logic [15:0] tbl_data;
    logic xclk, cam_rst, sioc, siod, siod_oe, busy, done;

    always #5 clk = ~clk;

    camera_init_ctrl #(
        .XCLK_DIV(XCLK_DIV), .SCCB_QTR(SCCB_QTR), .SLAVE_ADDR(SLAVE),
        .RST_HOLD(RST_HOLD), .RST_WAIT(RST_WAIT), .GAP_CYC(GAP_CYC),
        .DELAY_UNIT(DELAY_UNIT), .IDX_W(IDX_W), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .xclk(xclk), .cam_rst(cam_rst), .sioc(sioc), .siod(siod), .siod_oe(siod_oe),
        .busy(busy), .done(done)
    );

    // Synchronous table ROM: data valid one cycle after the address.
    logic [15:0] rom [16];
    always @(posedge clk) tbl_data <= rom[tbl_idx];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- SCCB bus monitor ----------------
    logic       p_sioc = 1'b1;
    logic       p_siod = 1'b1;
    int         mbit = 0;
    logic [7:0] msh = 8'h00;
    logic [7:0] mon_q [$];
    int         mon_oe_err = 0;

    always @(negedge clk) begin
        if (p_sioc && sioc && p_siod && !siod) begin
            mbit <= 0;
        end else if (!p_sioc && sioc) begin
            if (((mbit % 9) == 8) == (siod_oe === 1'b1)) mon_oe_err <= mon_oe_err + 1;
            if ((mbit % 9) == 8) mon_q.push_back(msh);
            msh  <= {msh[6:0], siod};
            mbit <= mbit + 1;
        end
        p_sioc <= sioc;
        p_siod <= siod;
    end

    // ---------------- Timeline reference model ----------------
    typedef struct packed {
        logic       cam_rst;
        logic [2:0] bus;     // {sioc, siod, siod_oe}
        logic       busy;
        logic       done;
        logic [3:0] idx;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] exp_bytes [$];
    int         last_done_cyc;

    function automatic void push(input logic cr, input logic [2:0] bus, input logic bz,
                                 input logic dn, input int ix, input int n);
        exp_t e;
        e.cam_rst = cr; e.bus = bus; e.busy = bz; e.done = dn; e.idx = ix[3:0];
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    // Waveform expected from the current ROM, counted from the first cycle of RST_LO.
    function automatic void build_model();
        int ix;
        logic [15:0] ent;
        logic [26:0] fr;
        logic v, oe;
        exp_q.delete();
        exp_bytes.delete();
        push(1'b0, 3'b111, 1'b1, 1'b0, 0, RST_HOLD);
        push(1'b1, 3'b111, 1'b1, 1'b0, 0, RST_WAIT);
        ix = 0;
        for (int k = 0; k < 16; k++) begin
            push(1'b1, 3'b111, 1'b1, 1'b0, ix, 2);
            ent = rom[ix];
            if (ent == 16'hFFFF) break;
            if (ent[15:8] == 8'hF0) begin
                push(1'b1, 3'b111, 1'b1, 1'b0, ix, int'(ent[7:0]) * DELAY_UNIT);
            end else begin
                exp_bytes.push_back(SLAVE);
                exp_bytes.push_back(ent[15:8]);
                exp_bytes.push_back(ent[7:0]);
                fr = {SLAVE, 1'b1, ent[15:8], 1'b1, ent[7:0], 1'b1};
                push(1'b1, 3'b101, 1'b1, 1'b0, ix, SCCB_QTR);
                push(1'b1, 3'b001, 1'b1, 1'b0, ix, SCCB_QTR);
                for (int b = 0; b < 27; b++) begin
                    oe = ((b % 9) != 8);
                    v  = oe ? fr[26 - b] : 1'b1;
                    push(1'b1, {1'b0, v, oe}, 1'b1, 1'b0, ix, SCCB_QTR);
                    push(1'b1, {1'b1, v, oe}, 1'b1, 1'b0, ix, 2 * SCCB_QTR);
                    push(1'b1, {1'b0, v, oe}, 1'b1, 1'b0, ix, SCCB_QTR);
                end
                push(1'b1, 3'b001, 1'b1, 1'b0, ix, SCCB_QTR);
                push(1'b1, 3'b101, 1'b1, 1'b0, ix, SCCB_QTR);
                push(1'b1, 3'b111, 1'b1, 1'b0, ix, SCCB_QTR);
                push(1'b1, 3'b111, 1'b1, 1'b0, ix, GAP_CYC);
            end
            if (ix == 15) break;
            ix++;
        end
        push(1'b1, 3'b111, 1'b0, 1'b1, ix, 40);
    endfunction

    function automatic void fill_rom(input logic [15:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endfunction

    // Launch a sequence (reset release or start pulse) and compare every cycle.
    task automatic run(input bit from_reset, input int start_at, input int stop_at,
                       input string name);
        int base_b, base_e, bad;
        logic [9:0] got;
        logic xe;
        build_model();
        base_b = mon_q.size();
        base_e = mon_oe_err;
        last_done_cyc = -1;
        bad = 0;
        start = 1'b0;
        if (from_reset) begin
            reset = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check({name, " reset_state"},
                  32'({xclk, cam_rst, sioc, siod, siod_oe, busy, done, tbl_idx}),
                  32'(11'b0_0_1_1_1_1_0_0000));
            reset = 1'b0;
        end else begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int c = 0; c < exp_q.size() && c < stop_at; c++) begin
            @(negedge clk);
            got = {cam_rst, sioc, siod, siod_oe, busy, done, tbl_idx};
            if (done === 1'b1 && last_done_cyc < 0) last_done_cyc = c;
            if (bad == 0) begin
                if (got !== exp_q[c]) bad = 1;
                check($sformatf("%s cyc%0d outputs", name, c), 32'(got), 32'(exp_q[c]));
                if (from_reset) begin
                    xe = 1'((c / (XCLK_DIV / 2)) % 2);
                    if (xclk !== xe) bad = 1;
                    check($sformatf("%s cyc%0d xclk", name, c), 32'(xclk), 32'(xe));
                end
            end
            start = (c == start_at);
        end
        start = 1'b0;
        if (stop_at > exp_q.size()) begin
            check({name, " byte_count"}, 32'(mon_q.size() - base_b), 32'(exp_bytes.size()));
            for (int i = 0; i < exp_bytes.size() && base_b + i < mon_q.size(); i++)
                check($sformatf("%s byte%0d", name, i), 32'(mon_q[base_b + i]), 32'(exp_bytes[i]));
            check({name, " oe_9th_bits"}, 32'(mon_oe_err - base_e), 32'd0);
        end
    endtask

    // Single-entry tables with hand-derived completion times.
    typedef struct {
        logic [15:0] entry;
        int          n_bytes;
        int          done_cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{16'h1280, 3, 258};  // one write: 24 + 2 + 230 + 2
        vecs[1] = '{16'hF005, 0, 78};   // 50-cycle delay: 24 + 2 + 50 + 2
        vecs[2] = '{16'hF000, 0, 28};   // zero-length delay: 24 + 2 + 2
        vecs[3] = '{16'hFFFF, 0, 26};   // immediate end marker
        fill_rom(16'hFFFF);

        for (int i = 0; i < 4; i++) begin
            int base_b;
            fill_rom(16'hFFFF);
            rom[0] = vecs[i].entry;
            base_b = mon_q.size();
            run(1'b1, -1, BIG, $sformatf("vec%0d", i));
            check($sformatf("vec%0d done_cycle", i), 32'(last_done_cyc), 32'(vecs[i].done_cyc));
            check($sformatf("vec%0d n_bytes", i), 32'(mon_q.size() - base_b), 32'(vecs[i].n_bytes));
        end

        // Two writes back to back; the second transaction ends at cycle 490.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run(1'b1, -1, BIG, "two_writes");
        check("two_writes done_cycle", 32'(last_done_cyc), 32'd490);

        // Delay entry followed by a write.
        fill_rom(16'hFFFF);
        rom[0] = 16'hF005; rom[1] = 16'h3A04;
        run(1'b1, -1, BIG, "delay_write");

        // Full table with no end marker: index stops at the last slot.
        for (int i = 0; i < 16; i++) rom[i] = {8'h20 + 8'(i), 8'(i * 3)};
        run(1'b1, -1, BIG, "full_table");
        check("full_table idx", 32'(tbl_idx), 32'd15);
        check("full_table done_busy", 32'({done, busy}), 32'(2'b10));

        // start during a transaction is ignored; start in DONE reruns everything.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run(1'b1, 100, BIG, "start_busy");
        run(1'b0, -1, BIG, "start_done");

        // Reset during bit 5 of the second byte (Q0, sioc low), then clean restart.
        run(1'b1, -1, 134, "rst_mid");
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid outputs",
              32'({sioc, siod, cam_rst, xclk, siod_oe, busy, done, tbl_idx}),
              32'(11'b1_1_0_0_1_1_0_0000));
        run(1'b1, -1, BIG, "rst_restart");

        // Randomised tables mixing writes, short delays and end markers.
        for (int r = 0; r < 5; r++) begin
            int len;
            len = (r == 4) ? 16 : $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                int kind;
                logic [7:0] a;
                kind = $urandom_range(0, 9);
                a = 8'($urandom);
                if (a == 8'hF0) a = 8'hF1;
                if (kind < 2) rom[i] = {8'hF0, 8'($urandom_range(0, 3))};
                else rom[i] = {a, 8'($urandom)};
            end
            if (len < 16) rom[len] = 16'hFFFF;
            run(1'b1, -1, BIG, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
